// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gating controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_ON    = 2'd0,
    CG_DRAIN = 2'd1,
    CG_OFF   = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int unsigned STATS_W = 16;

  function automatic int unsigned cg_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: low-transparent enable latch followed by an AND.
// Kept separate so a library ICG cell can be swapped in.
module clk_gate_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gated_clk
);

  logic r_en_l;

  always_latch begin
    if (!clk) r_en_l = en | test_en;
  end

  assign gated_clk = clk & r_en_l;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller with idle timeout and wake handshake.
// Optional per-channel gated-cycle statistics: define CLK_GATE_STATS_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           busy,
  input  logic [NUM_CH-1:0]           force_on,
  input  logic                        test_en,
`ifdef CLK_GATE_STATS_EN
  input  logic                        stats_clr,
  output logic [NUM_CH*STATS_W-1:0]   gated_cnt,
`endif
  output logic [NUM_CH-1:0]           gate_en,
  output logic [NUM_CH-1:0]           ready,
  output logic [NUM_CH-1:0]           gated_clk
);

  localparam int unsigned CNT_W = $clog2(cg_max(IDLE_CYCLES, WAKE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cg_state_e        r_state;
    cg_state_e        w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_gate_en;
    logic             r_ready;
    logic             w_active;

    assign w_active = busy[g] | force_on[g];

    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      unique case (r_state)
        CG_ON: begin
          w_cnt_nx = '0;
          if (!w_active) begin
            if (IDLE_CYCLES == 1) begin
              w_state_nx = CG_OFF;
            end else begin
              w_state_nx = CG_DRAIN;
              w_cnt_nx   = CNT_W'(1);
            end
          end
        end
        CG_DRAIN: begin
          // A request arriving on the expiry edge keeps the channel running.
          if (w_active) begin
            w_state_nx = CG_ON;
            w_cnt_nx   = '0;
          end else if (r_cnt == IDLE_LAST) begin
            w_state_nx = CG_OFF;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        CG_OFF: begin
          w_cnt_nx = '0;
          if (w_active) w_state_nx = (WAKE_CYCLES == 0) ? CG_ON : CG_WAKE;
        end
        CG_WAKE: begin
          if (r_cnt == WAKE_LAST) begin
            w_state_nx = CG_ON;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nx = CG_ON;
          w_cnt_nx   = '0;
        end
      endcase
    end

    // Outputs are registered from the next-state decode so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= CG_ON;
        r_cnt     <= '0;
        r_gate_en <= 1'b1;
        r_ready   <= 1'b1;
      end else begin
        r_state   <= w_state_nx;
        r_cnt     <= w_cnt_nx;
        r_gate_en <= (w_state_nx != CG_OFF);
        r_ready   <= (w_state_nx == CG_ON) || (w_state_nx == CG_DRAIN);
      end
    end

    assign gate_en[g] = r_gate_en;
    assign ready[g]   = r_ready;

    clk_gate_cell u_cell (
      .clk       (clk),
      .en        (r_gate_en),
      .test_en   (test_en),
      .gated_clk (gated_clk[g])
    );

`ifdef CLK_GATE_STATS_EN
    logic [STATS_W-1:0] r_gated_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_gated_cnt <= '0;
      end else if (stats_clr) begin
        r_gated_cnt <= '0;
      end else if (!r_gate_en && (r_gated_cnt != '1)) begin
        r_gated_cnt <= r_gated_cnt + STATS_W'(1);
      end
    end

    assign gated_cnt[g*STATS_W +: STATS_W] = r_gated_cnt;
`endif
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl (NUM_CH=4, IDLE_CYCLES=4, WAKE_CYCLES=2).
module tb_clk_gate_ctrl;

  localparam int KG = 0;
  localparam int KR = 1;
  localparam int KP = 2;
  localparam int KC = 3;

  typedef struct {
    int          cyc;
    int          kind;
    int          ch;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_en;
  logic [3:0] busy;
  logic [3:0] force_on;
  logic [3:0] gate_en;
  logic [3:0] ready;
  logic [3:0] gated_clk;
`ifdef CLK_GATE_STATS_EN
  logic        stats_clr;
  logic [63:0] gated_cnt;
`endif

  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  int          glitches = 0;
  int          n;
  logic [3:0]  last_pulse = '0;
  logic [3:0]  s_hi;
  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mon_act;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NUM_CH      (4),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy      (busy),
    .force_on  (force_on),
    .test_en   (test_en),
`ifdef CLK_GATE_STATS_EN
    .stats_clr (stats_clr),
    .gated_cnt (gated_cnt),
`endif
    .gate_en   (gate_en),
    .ready     (ready),
    .gated_clk (gated_clk)
  );

  always @(posedge clk) cyc++;

  // A gated high phase must be whole: same value just after the edge and just before the fall.
  always @(posedge clk) begin
    #1 s_hi = gated_clk;
    last_pulse = s_hi;
    #3 if (gated_clk !== s_hi) glitches++;
  end

  always @(negedge clk) begin
    #1 if (gated_clk !== 4'h0) glitches++;
    #3 if (gated_clk !== 4'h0) glitches++;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        KG:      mon_act = {12'h0, gate_en};
        KR:      mon_act = {12'h0, ready};
        KP:      mon_act = {12'h0, last_pulse};
`ifdef CLK_GATE_STATS_EN
        KC:      mon_act = gated_cnt[mon_e.ch*16 +: 16];
`endif
        default: mon_act = 16'hDEAD;
      endcase
      chk(mon_e.name, mon_act, mon_e.exp);
    end
  end

  task automatic push(input int c, input int k, input int ch, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic exp_gr(input int c, input logic [3:0] g, input logic [3:0] r, input string nm);
    push(c, KG, 0, {12'h0, g}, {nm, "_gate"});
    push(c, KR, 0, {12'h0, r}, {nm, "_ready"});
  endtask

  task automatic exp_p(input int c, input logic [3:0] p, input string nm);
    push(c, KP, 0, {12'h0, p}, {nm, "_pulse"});
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    busy     = '0;
    force_on = '0;
    test_en  = 1'b0;
`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    #1 rst_n = 1'b0;
    tick(2);

    // Reset held, then idle gate-off after 4 sampled idle edges
    n = cyc;
    exp_gr(n+1, 4'hF, 4'hF, "rst_hold");
    exp_p(n+1, 4'hF, "rst_hold");
    tick(1);
    rst_n = 1'b1;
    n = cyc;
    for (int k = 1; k <= 3; k++) begin
      exp_gr(n+k, 4'hF, 4'hF, "idle_on");
      exp_p(n+k, 4'hF, "idle_on");
    end
    exp_gr(n+4, 4'h0, 4'h0, "idle_off");
    exp_p(n+4, 4'hF, "idle_last");
`ifdef CLK_GATE_STATS_EN
    push(n+4, KC, 0, 16'h0000, "stat_start");
`endif
    exp_gr(n+5, 4'h0, 4'h0, "idle_stay");
    exp_p(n+5, 4'h0, "idle_none");
    exp_p(n+6, 4'h0, "idle_none2");
`ifdef CLK_GATE_STATS_EN
    push(n+7, KC, 0, 16'h0003, "stat_count");
`endif
    tick(7);

    // Channel 1 wake: enable at k, first pulse at k+1, ready at k+2
    n = cyc;
    busy = 4'b0010;
    exp_gr(n+1, 4'b0010, 4'b0000, "wake1_k");
    exp_p(n+1, 4'b0000, "wake1_k");
    exp_gr(n+2, 4'b0010, 4'b0000, "wake1_k1");
    exp_p(n+2, 4'b0010, "wake1_k1");
    exp_gr(n+3, 4'b0010, 4'b0010, "wake1_k2");
    exp_p(n+3, 4'b0010, "wake1_k2");
    tick(3);
    busy = '0;
    exp_gr(n+6, 4'b0010, 4'b0010, "ch1_drain");
    exp_gr(n+7, 4'b0000, 4'b0000, "ch1_off");
    exp_p(n+7, 4'b0010, "ch1_off");
    exp_p(n+8, 4'b0000, "ch1_stopped");
    tick(5);

    // Channel 0: request arriving on the drain expiry edge keeps it on
    n = cyc;
    busy = 4'b0001;
    tick(3);
    busy = '0;
    exp_gr(n+6, 4'b0001, 4'b0001, "drain_cnt3");
    tick(3);
    busy = 4'b0001;
    exp_gr(n+7, 4'b0001, 4'b0001, "expiry_race");
    exp_p(n+7, 4'b0001, "expiry_race");
    exp_p(n+8, 4'b0001, "expiry_race2");
    tick(2);
    busy = '0;
    exp_gr(n+11, 4'b0001, 4'b0001, "ch0_drain");
    exp_gr(n+12, 4'b0000, 4'b0000, "ch0_off");
    tick(4);

    // force_on holds channel 2 while the others time out
    n = cyc;
    force_on = 4'b0100;
    busy     = 4'b1011;
    exp_gr(n+1, 4'hF, 4'h0, "all_wake");
    exp_gr(n+3, 4'hF, 4'hF, "all_on");
    tick(3);
    busy = '0;
    exp_gr(n+6, 4'hF, 4'hF, "force_drain");
    exp_gr(n+7, 4'b0100, 4'b0100, "force_others_off");
    exp_gr(n+20, 4'b0100, 4'b0100, "force_hold");
    exp_p(n+20, 4'b0100, "force_hold");
    tick(17);
    force_on = '0;
    exp_gr(n+24, 4'h0, 4'h0, "force_release");
    tick(4);

    // test_en bypass with every channel off
    n = cyc;
    test_en = 1'b1;
    exp_gr(n+1, 4'h0, 4'h0, "test_en");
    exp_p(n+1, 4'hF, "test_en");
    exp_gr(n+3, 4'h0, 4'h0, "test_en3");
    exp_p(n+3, 4'hF, "test_en3");
    tick(3);
    test_en = 1'b0;
    exp_p(n+4, 4'h0, "test_drop");
    exp_gr(n+5, 4'h0, 4'h0, "test_drop");
    exp_p(n+5, 4'h0, "test_drop2");
    tick(5);

    // Asynchronous reset in the middle of channel 3 wake
    n = cyc;
    busy = 4'b1000;
    exp_gr(n+1, 4'b1000, 4'b0000, "wake3");
    tick(1);
    busy = '0;
    exp_gr(n+2, 4'hF, 4'hF, "rst_mid_wake");
    exp_p(n+2, 4'hF, "rst_mid_wake");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_gate", {12'h0, gate_en}, 16'h000F);
    chk("rst_async_ready", {12'h0, ready}, 16'h000F);
    tick(1);
    rst_n = 1'b1;
    n = cyc;
    exp_gr(n+1, 4'hF, 4'hF, "post_rst");
`ifdef CLK_GATE_STATS_EN
    push(n+1, KC, 3, 16'h0000, "stat_rst");
`endif
    exp_gr(n+3, 4'hF, 4'hF, "post_rst_drain");
    exp_gr(n+4, 4'h0, 4'h0, "post_rst_off");
`ifdef CLK_GATE_STATS_EN
    push(n+4, KC, 3, 16'h0000, "stat_off");
    push(n+7, KC, 3, 16'h0003, "stat_three");
`endif
    tick(7);

`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b1;
    push(cyc+1, KC, 3, 16'h0000, "stat_clr");
    tick(1);
    stats_clr = 1'b0;
    push(cyc+2, KC, 3, 16'h0002, "stat_after_clr");
    tick(2);
    tick(65540);
    push(cyc+1, KC, 3, 16'hFFFF, "stat_sat3");
    push(cyc+1, KC, 0, 16'hFFFF, "stat_sat0");
    tick(1);
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending", q.size());
    end
    chk("glitch_count", 16'(glitches), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
